// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between instruction
// fetch (IF) and load/store (LS). One access at a time, serialised through a
// small FSM. LS has fixed priority; an IF wait counter forces an IF win after
// MAX_WAIT consecutive LS wins while IF is waiting.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   if_req/if_addr             fetch request, held until if_gnt
//   if_gnt/if_rvalid/if_rdata  fetch grant pulse, read-data pulse, read data
//   ls_req/ls_we/ls_addr/ls_wdata  load/store request, held until ls_gnt
//   ls_gnt/ls_rvalid/ls_rdata  load/store grant pulse, load-data pulse, load data
//   mem_en/mem_we/mem_addr/mem_wdata  RAM command (word-aligned address)
//   mem_rdata                  RAM read data, valid the cycle after a read command
//   busy                       high while an access is in flight
//
// state  | meaning
// IDLE   | no access in flight; arbitrates at every edge
// ACCESS | RAM command on the bus, winner's gnt high
// RESP   | read data from RAM returned to the owner with rvalid
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} owner_t;

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  state_t            state, state_nxt;
  owner_t            owner, owner_nxt;
  logic [3:0]        wait_cnt, wait_nxt;
  logic              ls_wins;

  logic              if_gnt_nxt, ls_gnt_nxt;
  logic              if_rvalid_nxt, ls_rvalid_nxt;
  logic              mem_en_nxt, mem_we_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt;
  logic [DATA_W-1:0] if_rdata_q, ls_rdata_q;

  // byte-offset bits never reach the RAM
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[1:0], ls_addr[1:0]};

  // LS wins unless IF is also waiting and has already lost MAX_WAIT times
  assign ls_wins = ls_req && !(if_req && (wait_cnt >= WAIT_MAX));

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    wait_nxt      = wait_cnt;
    if_gnt_nxt    = 1'b0;
    ls_gnt_nxt    = 1'b0;
    if_rvalid_nxt = 1'b0;
    ls_rvalid_nxt = 1'b0;
    mem_en_nxt    = 1'b0;
    mem_we_nxt    = 1'b0;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    case (state)
      IDLE: begin
        if (if_req || ls_req) begin
          state_nxt     = ACCESS;
          mem_en_nxt    = 1'b1;
          mem_wdata_nxt = ls_wdata;
          if (ls_wins) begin
            owner_nxt    = OWN_LS;
            ls_gnt_nxt   = 1'b1;
            mem_we_nxt   = ls_we;
            mem_addr_nxt = {ls_addr[ADDR_W-1:2], 2'b00};
            if (!if_req)
              wait_nxt = '0;
            else if (wait_cnt < WAIT_MAX)
              wait_nxt = wait_cnt + 4'd1;
          end else begin
            owner_nxt    = OWN_IF;
            if_gnt_nxt   = 1'b1;
            mem_addr_nxt = {if_addr[ADDR_W-1:2], 2'b00};
            wait_nxt     = '0;
          end
        end else begin
          wait_nxt = '0;
        end
      end
      ACCESS: begin
        if (mem_we) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = RESP;
          if (owner == OWN_IF) if_rvalid_nxt = 1'b1;
          else                 ls_rvalid_nxt = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= OWN_IF;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if_gnt     <= 1'b0;
      ls_gnt     <= 1'b0;
      if_rvalid  <= 1'b0;
      ls_rvalid  <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      if_gnt    <= if_gnt_nxt;
      ls_gnt    <= ls_gnt_nxt;
      if_rvalid <= if_rvalid_nxt;
      ls_rvalid <= ls_rvalid_nxt;
      mem_en    <= mem_en_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      busy      <= (state_nxt != IDLE);
      if (if_rvalid) if_rdata_q <= mem_rdata;
      if (ls_rvalid) ls_rdata_q <= mem_rdata;
    end
  end

  // The RAM's output is already a register, so during RESP its data is
  // forwarded straight to the owner; the captured copy holds it afterwards.
  assign if_rdata = if_rvalid ? mem_rdata : if_rdata_q;
  assign ls_rdata = ls_rvalid ? mem_rdata : ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, ls_req, ls_we;
  logic [AW-1:0] if_addr, ls_addr;
  logic [DW-1:0] ls_wdata;
  logic          if_gnt, if_rvalid, ls_gnt, ls_rvalid;
  logic [DW-1:0] if_rdata, ls_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] init_word(int w);
    return (w == 2) ? 32'h00500093 : (32'hA5A50000 | 32'(w));
  endfunction

  // ---------------- RAM device ----------------
  logic [31:0] ram [int];
  logic [31:0] rd_q;
  always @(posedge clk) begin : ram_dev
    int k;
    k = int'(mem_addr[9:2]);
    if (mem_en && mem_we) ram[k] = mem_wdata;
    if (mem_en && !mem_we) rd_q <= ram.exists(k) ? ram[k] : init_word(k);
    else                   rd_q <= $urandom;   // garbage outside read responses
  end
  assign mem_rdata = rd_q;

  // ---------------- reference model ----------------
  typedef struct {
    int          tag;
    bit          who;    // 0 = IF, 1 = LS
    logic [31:0] addr;
    bit          we;
    logic [31:0] data;
  } ev_t;

  ev_t         gnt_q[$];
  ev_t         rv_q[$];
  int          ecount   = 0;
  int          busy_end = -2;   // last edge after which busy is still high
  int          consec   = 0;    // LS wins in a row while IF waited
  bit          exp_busy = 1'b0;
  int          rst_gen  = 0;
  string       grant_log = "";
  logic [31:0] ref_mem [int];

  always @(posedge clk) begin : model
    int  e;
    bit  ls_win;
    ev_t g;
    ev_t r;
    e = ecount;
    ecount++;
    if (reset) begin
      gnt_q.delete();
      rv_q.delete();
      busy_end = e - 1;
      consec   = 0;
      rst_gen++;
    end else if (e >= busy_end + 2) begin
      if (if_req || ls_req) begin
        ls_win = ls_req && !(if_req && consec == MW);
        g.tag  = e + 1;
        g.who  = ls_win;
        g.we   = ls_win && ls_we;
        g.addr = (ls_win ? ls_addr : if_addr) & ~32'h3;
        g.data = ls_wdata;
        gnt_q.push_back(g);
        if (ls_win) grant_log = {grant_log, "L"};
        else        grant_log = {grant_log, "I"};
        if (g.we) begin
          ref_mem[int'(g.addr >> 2)] = ls_wdata;
          busy_end = e;
        end else begin
          r.tag  = e + 2;
          r.who  = ls_win;
          r.addr = g.addr;
          r.we   = 1'b0;
          r.data = ref_mem.exists(int'(g.addr >> 2)) ? ref_mem[int'(g.addr >> 2)]
                                                      : init_word(int'(g.addr >> 2));
          rv_q.push_back(r);
          busy_end = e + 1;
        end
        if (!ls_win)     consec = 0;
        else if (if_req) consec = (consec < MW) ? consec + 1 : MW;
        else             consec = 0;
      end else begin
        consec = 0;
      end
    end
    exp_busy = (e <= busy_end);
  end

  // ---------------- monitor / scoreboard ----------------
  logic [31:0] last_if = '0;
  logic [31:0] last_ls = '0;
  int          seen_rst = 0;

  always @(negedge clk) begin : monitor
    ev_t x;
    if (seen_rst != rst_gen) begin
      seen_rst = rst_gen;
      last_if  = '0;
      last_ls  = '0;
    end
    check("busy", 32'(busy), 32'(exp_busy));
    check("gnt_exclusive", 32'(if_gnt & ls_gnt), 0);
    check("rvalid_exclusive", 32'(if_rvalid & ls_rvalid), 0);
    if (if_gnt || ls_gnt) begin
      if (gnt_q.size() == 0) begin
        check("gnt_unexpected", 32'(if_gnt | ls_gnt), 0);
      end else begin
        x = gnt_q.pop_front();
        check("gnt_cycle", ecount, x.tag);
        check("gnt_owner", 32'(ls_gnt), 32'(x.who));
        check("gnt_mem_en", 32'(mem_en), 1);
        check("gnt_mem_addr", mem_addr, x.addr);
        check("gnt_mem_we", 32'(mem_we), 32'(x.we));
        if (x.we) check("gnt_mem_wdata", mem_wdata, x.data);
      end
    end else begin
      check("mem_en_idle", 32'(mem_en), 0);
      check("mem_we_idle", 32'(mem_we), 0);
      if (gnt_q.size() > 0 && gnt_q[0].tag <= ecount) begin
        x = gnt_q.pop_front();
        check("gnt_missing", 32'(if_gnt | ls_gnt), 1);
      end
    end
    if (if_rvalid || ls_rvalid) begin
      if (rv_q.size() == 0) begin
        check("rvalid_unexpected", 32'(if_rvalid | ls_rvalid), 0);
      end else begin
        x = rv_q.pop_front();
        check("rvalid_cycle", ecount, x.tag);
        check("rvalid_owner", 32'(ls_rvalid), 32'(x.who));
        if (x.who) begin
          check("ls_rdata", ls_rdata, x.data);
          check("if_rdata_hold", if_rdata, last_if);
          last_ls = x.data;
        end else begin
          check("if_rdata", if_rdata, x.data);
          check("ls_rdata_hold", ls_rdata, last_ls);
          last_if = x.data;
        end
      end
    end else if (rv_q.size() > 0 && rv_q[0].tag <= ecount) begin
      x = rv_q.pop_front();
      check("rvalid_missing", 32'(if_rvalid | ls_rvalid), 1);
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
  endfunction

  task automatic do_req(input bit who, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat);
    int t;
    if (who) begin
      ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(who ? ls_gnt : if_gnt) && t < 20);
    check("req_granted", 32'(who ? ls_gnt : if_gnt), 1);
    if (who) ls_req = 1'b0;
    else     if_req = 1'b0;
    lat = t;
  endtask

  initial begin
    int lat;
    int ngr;
    int log_start;
    string seq;
    reset = 1'b1; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_if_gnt", 32'(if_gnt), 0);
    check("rst_ls_gnt", 32'(ls_gnt), 0);
    check("rst_if_rvalid", 32'(if_rvalid), 0);
    check("rst_ls_rvalid", 32'(ls_rvalid), 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_ls_rdata", ls_rdata, 0);
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_busy", 32'(busy), 0);
    reset = 1'b0;

    // fetch from 0x8
    do_req(1'b0, 1'b0, 32'h8, 32'h0, lat);
    check("if_first_latency", lat, 1);
    check("if_first_mem_addr", mem_addr, 32'h8);
    @(negedge clk);
    check("if_first_rvalid", 32'(if_rvalid), 1);
    check("if_first_rdata", if_rdata, 32'h00500093);

    // store then load at 0x10
    do_req(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, lat);
    check("st_mem_we", 32'(mem_we), 1);
    check("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
    do_req(1'b1, 1'b0, 32'h10, 32'h0, lat);
    check("st_to_ld_latency", lat, 2);
    @(negedge clk);
    check("ld_rvalid", 32'(ls_rvalid), 1);
    check("ld_rdata", ls_rdata, 32'hDEADBEEF);

    // reset during ACCESS of a read
    do_req(1'b0, 1'b0, 32'h8, 32'h0, lat);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_no_rvalid", 32'(if_rvalid), 0);
    do_req(1'b1, 1'b0, 32'h13, 32'h0, lat);
    check("post_reset_latency", lat, 1);
    check("unaligned_mem_addr", mem_addr, 32'h10);
    repeat (3) @(negedge clk);

    // both held continuously: anti-starvation order
    log_start = grant_log.len();
    if_req = 1'b1; if_addr = 32'h20;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h24;
    ngr = 0;
    for (int c = 0; c < 100 && ngr < 8; c++) begin
      @(negedge clk);
      if (if_gnt || ls_gnt) ngr++;
    end
    if_req = 1'b0; ls_req = 1'b0;
    check("held_grant_count", ngr, 8);
    seq = grant_log.substr(log_start, log_start + 7);
    n_checks++;
    if (seq != "LLLILLLI") begin
      n_fail++;
      $display("FAIL grant_order: got %s expected LLLILLLI", seq);
    end
    repeat (3) @(negedge clk);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (if_gnt) if_req = 1'b0;
      if (ls_gnt) ls_req = 1'b0;
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = rand_addr();
      end
      if (!ls_req && $urandom_range(0, 2) == 0) begin
        ls_req = 1'b1; ls_we = 1'($urandom_range(0, 1));
        ls_addr = rand_addr(); ls_wdata = $urandom;
      end
      reset = ($urandom_range(0, 399) == 0);
    end
    @(negedge clk);
    reset = 1'b0;
    if (if_gnt) if_req = 1'b0;
    if (ls_gnt) ls_req = 1'b0;
    for (int c = 0; c < 40 && (if_req || ls_req); c++) begin
      @(negedge clk);
      if (if_gnt) if_req = 1'b0;
      if (ls_gnt) ls_req = 1'b0;
    end
    if_req = 1'b0; ls_req = 1'b0;
    repeat (6) @(negedge clk);
    check("drain_queues", gnt_q.size() + rv_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
